exc_controller: RTL
===================

// Module: exc_controller
// PURPOSE
//  Exception/interrupt source controller upstream of the datapath. It collects events and
//  prioritises them into a 4-bit EStatus cause code.
//  - Event sources: decoder invalid-opcode, external IRQ, internal timer.
//  - Drives Exc/EStatus into the datapath, consumes its ExcAck.
//  - Masks new exceptions while the handler runs; issues ERet when the handler's ERET decodes.
// PARAMETERS
//  TIMER_W   32   width of timer counter and compare value
// PORTS
//  clk        in   1        system clock, all state on rising edge
//  reset      in   1        asynchronous, active-low reset (0 = reset)
//  BadOpcode  in   1        1-cycle pulse from decode: unimplemented opcode
//  ExtIRQ     in   1        external interrupt, level, asynchronous to clk
//  IsERet     in   1        decode flags the current instruction as ERET
//  ExcAck     in   1        datapath has vectored to the handler (EVAddr taken)
//  TimerCmp   in   TIMER_W  timer period in cycles; 0 = timer disabled
//  Exc        out  1        exception request to datapath
//  EStatus    out  4        cause code, valid while Exc=1 and held during handler
//  ERet       out  1        1-cycle return pulse to datapath
//  InHandler  out  1        1 while in REQ or HANDLER (exceptions masked)
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): state=IDLE; Exc=0, EStatus=4'b0000, ERet=0, InHandler=0.
//    Reset also clears the pending bits, the timer count and the synchroniser flops.
//  - Cause codes: 4'b0001 BadOpcode, 4'b0010 ExtIRQ, 4'b0011 Timer.
//    Fixed priority: BadOpcode > ExtIRQ > Timer.
//  - Pending bits pend[2:0], one per source:
//    - Each bit is set on its event in any state.
//    - Only the bit of the accepted cause clears, on the ExcAck edge.
//    - Set wins over clear in the same cycle.
//  - ExtIRQ path: through a 2-flop synchroniser, then a rising-edge detect. Edge sets pend[1].
//  - Timer:
//    - Count increments every cycle while TimerCmp!=0.
//    - When count==TimerCmp-1, pend[2] is set and count wraps to 0.
//    - A TimerCmp change resets count to 0.
//  - FSM states: IDLE, REQ, HANDLER, RET.
//    - IDLE: if any pend bit is set, latch EStatus = highest-priority code and go to REQ.
//      Exc=1 from the next cycle, so BadOpcode at edge t gives Exc=1 in cycle t+1.
//    - REQ: Exc=1 and EStatus is held stable until ExcAck=1. Then clear that pend bit,
//      Exc=0 next cycle, go to HANDLER.
//    - HANDLER: Exc=0 and EStatus is held. On IsERet go to RET.
//    - RET: ERet=1 for exactly one cycle, EStatus is cleared to 0, go to IDLE.
//  - Boundaries:
//    - IsERet in IDLE or REQ: ignored, no ERet pulse.
//    - ExcAck outside REQ: ignored.
//    - Event during REQ/HANDLER/RET: pends and is serviced after return to IDLE.
//    - Two events arriving back-to-back: serviced in priority order, one REQ each.
//    - IsERet and a new event in the same HANDLER cycle: ERet path wins, the event pends.
//    - A higher-priority event arriving during REQ does not change the latched EStatus.
//    - Timer wrap while pend[2] is already set: no double count; the bit simply stays set.
//    - Reset mid-REQ or mid-HANDLER: immediate IDLE, all pending lost.
//  - Exc, EStatus, ERet and InHandler are all registered outputs; there are no
//    combinational input-to-output paths.
// CONFIGURATION
//  - EXC_TIMER_EN defined: the timer counter and the pend[2] source are built.
//  - EXC_TIMER_EN undefined: TimerCmp is ignored, no counter is synthesised,
//    code 4'b0011 is never produced, and pend[2] is tied to 0.
// STRUCTURE
//  - Shared package exc_pkg:
//    - typedef enum logic [1:0] {IDLE, REQ, HANDLER, RET} exc_state_t;
//    - localparams ECODE_NONE, ECODE_BADOP, ECODE_IRQ, ECODE_TIMER (4-bit).
//    - The datapath exception unit imports the same codes.
//  - Sub-module sync_2ff: 2-flop synchroniser with async active-low reset, used for ExtIRQ.
// TESTING
//  1. Reset released, no events for 20 cycles -> Exc=0, EStatus=0, ERet=0, InHandler=0 throughout.
//  2. BadOpcode pulse at cycle 5 -> Exc=1, EStatus=0001 at cycle 6; ExcAck at 8 -> Exc=0 at 9;
//     IsERet at 12 -> ERet=1 at 13 only.
//  3. BadOpcode and ExtIRQ rise together -> first REQ EStatus=0001; after ERet, second REQ EStatus=0010
//     (IRQ visible 2 cycles later via sync).
//  4. TimerCmp=10, EXC_TIMER_EN defined -> Exc with EStatus=0011 every 10 cycles when acked promptly;
//     TimerCmp=0 -> never. With the macro undefined -> never.
//  5. IsERet in IDLE and ExcAck in IDLE -> no ERet, no state change; BadOpcode during HANDLER pends,
//     REQ issued the cycle after RET.
//  6. Assert reset=0 while in REQ with pend[1] set -> outputs immediately 0;
//     after release, no REQ without a new event.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared exception cause codes, FSM state type and priority helpers.
// Also imported by the datapath exception unit.
package exc_pkg;

    typedef enum logic [1:0] {IDLE, REQ, HANDLER, RET} exc_state_t;

    localparam logic [3:0] ECODE_NONE  = 4'b0000;
    localparam logic [3:0] ECODE_BADOP = 4'b0001;
    localparam logic [3:0] ECODE_IRQ   = 4'b0010;
    localparam logic [3:0] ECODE_TIMER = 4'b0011;

    // pend[0]=BadOpcode, pend[1]=ExtIRQ, pend[2]=Timer; lower index wins.
    function automatic logic [3:0] prio_code(input logic [2:0] pend);
        logic [3:0] code;
        code = ECODE_NONE;
        if (pend[2]) code = ECODE_TIMER;
        if (pend[1]) code = ECODE_IRQ;
        if (pend[0]) code = ECODE_BADOP;
        return code;
    endfunction

    function automatic logic [2:0] code_mask(input logic [3:0] code);
        logic [2:0] mask;
        case (code)
            ECODE_BADOP: mask = 3'b001;
            ECODE_IRQ:   mask = 3'b010;
            ECODE_TIMER: mask = 3'b100;
            default:     mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/exc_controller_sync_2ff.sv
// Two-flop synchroniser for an asynchronous level input; async active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/exc_controller.sv
// Exception source controller: pends BadOpcode/ExtIRQ/Timer events and runs the
// REQ/HANDLER/RET handshake with the datapath. Timer source built only with EXC_TIMER_EN.
module exc_controller
    import exc_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               BadOpcode,
    input  logic               ExtIRQ,
    input  logic               IsERet,
    input  logic               ExcAck,
    input  logic [TIMER_W-1:0] TimerCmp,
    output logic               Exc,
    output logic [3:0]         EStatus,
    output logic               ERet,
    output logic               InHandler
);

    exc_state_t state_q, state_d;
    logic [2:0] pend_q, pend_d, pend_set, pend_clr, pend_eff;
    logic [3:0] estatus_q, estatus_d;
    logic       exc_q, eret_q, inh_q;
    logic       irq_sync, irq_prev_q, irq_rise;
    logic       timer_fire;

    sync_2ff u_irq_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (ExtIRQ),
        .q_o   (irq_sync)
    );

    assign irq_rise = irq_sync & ~irq_prev_q;

`ifdef EXC_TIMER_EN
    logic [TIMER_W-1:0] count_q, count_d, cmp_q;
    localparam logic [TIMER_W-1:0] ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

    // A changed period restarts the count without firing.
    always_comb begin
        count_d    = count_q;
        timer_fire = 1'b0;
        if (TimerCmp != cmp_q) begin
            count_d = '0;
        end else if (TimerCmp != '0) begin
            if (count_q == TimerCmp - ONE) begin
                timer_fire = 1'b1;
                count_d    = '0;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            cmp_q   <= '0;
        end else begin
            count_q <= count_d;
            cmp_q   <= TimerCmp;
        end
    end
`else
    logic unused_timer_cmp;
    assign unused_timer_cmp = ^TimerCmp;
    assign timer_fire       = 1'b0;
`endif

    assign pend_set = {timer_fire, irq_rise, BadOpcode};
    assign pend_eff = pend_q | pend_set;

    always_comb begin
        state_d   = state_q;
        estatus_d = estatus_q;
        pend_clr  = 3'b000;
        case (state_q)
            IDLE: begin
                if (pend_eff != 3'b000) begin
                    state_d   = REQ;
                    estatus_d = prio_code(pend_eff);
                end
            end
            REQ: begin
                if (ExcAck) begin
                    state_d  = HANDLER;
                    pend_clr = code_mask(estatus_q);
                end
            end
            HANDLER: begin
                if (IsERet) begin
                    state_d   = RET;
                    estatus_d = ECODE_NONE;
                end
            end
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A set arriving with the clear keeps the bit pending.
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pend_q     <= 3'b000;
            estatus_q  <= ECODE_NONE;
            exc_q      <= 1'b0;
            eret_q     <= 1'b0;
            inh_q      <= 1'b0;
            irq_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            estatus_q  <= estatus_d;
            exc_q      <= (state_d == REQ);
            eret_q     <= (state_d == RET);
            inh_q      <= (state_d == REQ) || (state_d == HANDLER);
            irq_prev_q <= irq_sync;
        end
    end

    assign Exc       = exc_q;
    assign EStatus   = estatus_q;
    assign ERet      = eret_q;
    assign InHandler = inh_q;

endmodule
